// File: rtl/tff_pkg.sv
// Shared definitions for the T flip-flop sequencer: command op codes and controller states.
package tff_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_UP    = 2'd2,
    OP_DOWN  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/tff.sv
// Single T flip-flop cell: toggles Q on a clock edge where T is high.
module tff (
  input  logic T,
  input  logic clk,
  input  logic reset,
  output logic Q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      Q <= 1'b0;
    end else if (T) begin
      Q <= ~Q;
    end
  end

endmodule

// File: rtl/tff_seq_ctrl_bank.sv
// Bank of WIDTH T flip-flop cells sharing clock and reset, one toggle enable per cell.
module tff_seq_ctrl_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] t_vec_i,
  output logic [WIDTH-1:0] q_o
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    tff u_tff (
      .T     (t_vec_i[gi]),
      .clk   (clk),
      .reset (reset),
      .Q     (q_o[gi])
    );
  end

endmodule

// File: rtl/tff_seq_ctrl.sv
// Command sequencer for a T flip-flop bank: clear, load and count up/down by N using toggles only.
// state | meaning
// IDLE  | ready for a command, bank held
// APPLY | one-cycle clear/load via q-dependent toggles
// RUN   | one count step per cycle until counter hits 1 or abort
// DONE  | one-cycle completion pulse, status valid
module tff_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int OP_W  = tff_pkg::OP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             wrapped,
  output logic             aborted,
  output logic [WIDTH-1:0] q
);

  import tff_pkg::*;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrapped_q, wrapped_d;
  logic             aborted_q, aborted_d;
  logic [WIDTH-1:0] t_vec;
  logic             accept;
  logic             step_wraps;

  // A bit toggles when every lower bit of v is 1; v=q counts up, v=~q counts down.
  function automatic logic [WIDTH-1:0] carry_t(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] t;
    t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t[i] = t[i-1] & v[i-1];
    end
    return t;
  endfunction

  assign accept = cmd_valid && (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (op_e'(cmd_op) == OP_CLEAR || op_e'(cmd_op) == OP_LOAD) begin
            state_d = ST_APPLY;
          end else if (cmd_arg == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_APPLY: state_d = ST_DONE;
      ST_RUN: begin
        if (abort || cnt_q == WIDTH'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
  end

  // Toggle vector: APPLY flips exactly the bits that differ from the target.
  always_comb begin
    t_vec = '0;
    unique case (state_q)
      ST_APPLY: t_vec = (op_q == OP_LOAD) ? (q ^ arg_q) : q;
      ST_RUN: begin
        if (!abort) begin
          t_vec = (op_q == OP_UP) ? carry_t(q) : carry_t(~q);
        end
      end
      default: t_vec = '0;
    endcase
  end

  assign step_wraps = (op_q == OP_UP) ? (&q) : ~(|q);

  always_comb begin
    op_d      = op_q;
    arg_d     = arg_q;
    cnt_d     = cnt_q;
    wrapped_d = wrapped_q;
    aborted_d = aborted_q;
    if (accept) begin
      op_d      = op_e'(cmd_op);
      arg_d     = cmd_arg;
      cnt_d     = cmd_arg;
      wrapped_d = 1'b0;
      aborted_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      cnt_d = cnt_q - WIDTH'(1);
      if (abort) begin
        aborted_d = 1'b1;
      end else if (step_wraps) begin
        wrapped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= OP_CLEAR;
      arg_q     <= '0;
      cnt_q     <= '0;
      wrapped_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      arg_q     <= arg_d;
      cnt_q     <= cnt_d;
      wrapped_q <= wrapped_d;
      aborted_q <= aborted_d;
    end
  end

  assign wrapped = wrapped_q;
  assign aborted = aborted_q;

  tff_seq_ctrl_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .t_vec_i (t_vec),
    .q_o     (q)
  );

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Self-checking bench for tff_seq_ctrl: directed command table, random commands vs an arithmetic model, corner sequences.
module tb_tff_seq_ctrl;

  localparam int W = 4;
  localparam logic [1:0] C_CLEAR = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_UP    = 2'd2;
  localparam logic [1:0] C_DOWN  = 2'd3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'd0;
  logic [W-1:0] cmd_arg = '0;
  logic         abort = 1'b0;
  logic         busy, done, wrapped, aborted;
  logic [W-1:0] q;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] mdl_q;

  tff_seq_ctrl #(.WIDTH(W), .OP_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .wrapped   (wrapped),
    .aborted   (aborted),
    .q         (q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] arg;
    int           abort_k;
    logic [W-1:0] eq;
    logic         ewr;
    logic         eab;
    int           elat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Whole-command reference: plain modular arithmetic on the count.
  task automatic model_cmd(input logic [1:0] op, input logic [W-1:0] arg, input int k,
                           input logic [W-1:0] cur, output logic [W-1:0] eq,
                           output logic ewr, output logic eab, output int elat);
    int steps, v;
    ewr = 1'b0; eab = 1'b0;
    if (op == C_CLEAR) begin eq = '0; elat = 1; end
    else if (op == C_LOAD) begin eq = arg; elat = 1; end
    else if (arg == 0) begin eq = cur; elat = 0; end
    else begin
      if (k >= 1 && k <= int'(arg)) begin steps = k - 1; eab = 1'b1; elat = k; end
      else begin steps = int'(arg); elat = int'(arg); end
      v = (op == C_UP) ? int'(cur) + steps : int'(cur) - steps;
      ewr = (v < 0) || (v >= 16);
      eq = W'((v + 16) % 16);
    end
  endtask

  // Issue one command, apply abort in post-accept cycle abort_k (1-based), check steps and completion.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [W-1:0] arg,
                         input int abort_k, input logic [W-1:0] eq, input logic ewr,
                         input logic eab, input int elat);
    int c = 0;
    int steps;
    logic [W-1:0] mq = mdl_q;
    steps = eab ? elat - 1 : elat;
    chk({tag, "_ready"}, int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    tick();
    cmd_valid = 1'b0;
    while (done !== 1'b1 && c < 40) begin
      abort = (c + 1 == abort_k);
      tick();
      abort = 1'b0;
      c++;
      if ((op == C_UP || op == C_DOWN) && c <= steps) begin
        mq = (op == C_UP) ? mq + W'(1) : mq - W'(1);
        chk({tag, "_step_q"}, int'(q), int'(mq));
      end
    end
    if (done !== 1'b1) chk({tag, "_timeout_done"}, 0, 1);
    chk({tag, "_latency"}, c, elat);
    chk({tag, "_q"}, int'(q), int'(eq));
    chk({tag, "_wrapped"}, int'(wrapped), int'(ewr));
    chk({tag, "_aborted"}, int'(aborted), int'(eab));
    chk({tag, "_busy"}, int'(busy), 1);
    tick();
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_idle_ready"}, int'(cmd_ready), 1);
    chk({tag, "_wr_hold"}, int'(wrapped), int'(ewr));
    chk({tag, "_ab_hold"}, int'(aborted), int'(eab));
    mdl_q = eq;
  endtask

  vec_t tbl[15];

  initial begin
    logic [W-1:0] r_eq;
    logic r_wr, r_ab;
    int r_lat, r_k;
    logic [1:0] r_op;
    logic [W-1:0] r_arg;

    //            op       arg    ab   eq    wr    ab    lat
    tbl[0]  = '{C_CLEAR, 4'h0,  0, 4'h0, 1'b0, 1'b0, 1};
    tbl[1]  = '{C_UP,    4'd5,  0, 4'h5, 1'b0, 1'b0, 5};
    tbl[2]  = '{C_LOAD,  4'hE,  0, 4'hE, 1'b0, 1'b0, 1};
    tbl[3]  = '{C_UP,    4'd3,  0, 4'h1, 1'b1, 1'b0, 3};
    tbl[4]  = '{C_LOAD,  4'h9,  0, 4'h9, 1'b0, 1'b0, 1};
    tbl[5]  = '{C_CLEAR, 4'h7,  0, 4'h0, 1'b0, 1'b0, 1};
    tbl[6]  = '{C_UP,    4'd0,  0, 4'h0, 1'b0, 1'b0, 0};
    tbl[7]  = '{C_UP,    4'd10, 4, 4'h3, 1'b0, 1'b1, 4};
    tbl[8]  = '{C_CLEAR, 4'h0,  0, 4'h0, 1'b0, 1'b0, 1};
    tbl[9]  = '{C_DOWN,  4'd2,  0, 4'hE, 1'b1, 1'b0, 2};
    tbl[10] = '{C_UP,    4'd1,  1, 4'hE, 1'b0, 1'b1, 1};
    tbl[11] = '{C_DOWN,  4'd15, 0, 4'hF, 1'b1, 1'b0, 15};
    tbl[12] = '{C_LOAD,  4'h5,  1, 4'h5, 1'b0, 1'b0, 1};
    tbl[13] = '{C_LOAD,  4'h0,  0, 4'h0, 1'b0, 1'b0, 1};
    tbl[14] = '{C_DOWN,  4'd0,  0, 4'h0, 1'b0, 1'b0, 0};

    reset = 1'b1;
    tick();
    tick();
    chk("rst_q", int'(q), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wrapped", int'(wrapped), 0);
    chk("rst_aborted", int'(aborted), 0);
    reset = 1'b0;
    mdl_q = '0;
    tick();

    for (int i = 0; i < 15; i++) begin
      run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].arg, tbl[i].abort_k,
              tbl[i].eq, tbl[i].ewr, tbl[i].eab, tbl[i].elat);
    end

    // cmd_valid while busy must not be accepted
    cmd_valid = 1'b1; cmd_op = C_UP; cmd_arg = 4'd3;
    tick();
    cmd_op = C_LOAD; cmd_arg = 4'hF;
    tick();
    chk("busy_ready_low", int'(cmd_ready), 0);
    tick();
    cmd_valid = 1'b0;
    chk("busy_q2", int'(q), 2);
    tick();
    chk("busy_done", int'(done), 1);
    chk("busy_q3", int'(q), 3);
    tick();
    tick();
    chk("busy_q_after", int'(q), 3);
    chk("busy_still_idle", int'(busy), 0);

    // reset in the middle of a RUN
    cmd_valid = 1'b1; cmd_op = C_UP; cmd_arg = 4'd8;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("midrst_q_before", int'(q), 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_q", int'(q), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    tick();
    chk("midrst_q_hold", int'(q), 0);
    mdl_q = '0;

    for (int i = 0; i < 40; i++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_arg = W'($urandom_range(0, 15));
      r_k   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16)) : 0;
      model_cmd(r_op, r_arg, r_k, mdl_q, r_eq, r_wr, r_ab, r_lat);
      run_cmd($sformatf("rnd%0d", i), r_op, r_arg, r_k, r_eq, r_wr, r_ab, r_lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
